// File: rtl/fads_sort_scheduler_if.sv
// ============================================================================
// fads_sort_scheduler_if : classifier-side request/trigger bundle of the
//                          sort scheduler.  Rev 1.0
// ============================================================================
`default_nettype none

interface fads_sort_scheduler_if #(
   parameter int QLOG2 = 3
);
   logic             sort_req_i;
   logic             enable_i;
   logic             flush_i;
   logic             sort_trig_o;
   logic             busy_o;
   logic [QLOG2:0]   level_o;

   modport master (
      output sort_req_i, enable_i, flush_i,
      input  sort_trig_o, busy_o, level_o
   );

   modport slave (
      input  sort_req_i, enable_i, flush_i,
      output sort_trig_o, busy_o, level_o
   );
endinterface

`default_nettype wire

// File: rtl/fads_sort_scheduler.sv
// ============================================================================
// fads_sort_scheduler : FIFO of due timestamps that issues one guarded
//                       sort-trigger pulse per positive droplet.  Rev 1.0
// ============================================================================
`default_nettype none

module fads_sort_scheduler #(
   parameter int             QLOG2   = 3,
   parameter int             TW      = 32,
   parameter logic [TW-1:0]  TS_INIT = '0
) (
   input  wire logic              adc_clk_i,
   input  wire logic              adc_rst_i,
   fads_sort_scheduler_if.slave   bus,
   input  wire logic              cnt_clr_i,
   input  wire logic [TW-1:0]     cfg_delay_i,
   input  wire logic [TW-1:0]     cfg_duration_i,
   input  wire logic [TW-1:0]     cfg_guard_i,
   input  wire logic [TW-1:0]     cfg_late_tol_i,
   output logic      [TW-1:0]     issued_cnt_o,
   output logic      [TW-1:0]     dropped_cnt_o
);

   localparam int DEPTH = 1 << QLOG2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_PULSE = 2'd2;
   localparam logic [1:0] S_GUARD = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [TW-1:0]    ts_q, ts_d;
   logic [TW-1:0]    due_mem_q [DEPTH];
   logic [TW-1:0]    due_mem_d [DEPTH];
   logic [QLOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [QLOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [QLOG2:0]   level_q, level_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [TW-1:0]    guard_q, guard_d;
   logic [TW-1:0]    issued_cnt_q, issued_cnt_d;
   logic [TW-1:0]    dropped_cnt_q, dropped_cnt_d;
   logic             trig_q, trig_d;

   logic             q_empty, q_full;
   logic [TW-1:0]    lateness;
   logic             head_due, head_late;
   logic             pop, fire, late_drop;
   logic             push_req, push_ok, ovf_drop;
   logic [1:0]       drop_n;
   logic [TW:0]      drop_sum;

   assign q_empty   = (level_q == '0);
   assign q_full    = (level_q == (QLOG2+1)'(DEPTH));
   // Wrap-aware compare: the head is due once ts has reached it (MSB clear).
   assign lateness  = ts_q - due_mem_q[rd_ptr_q];
   assign head_due  = ~lateness[TW-1];
   assign head_late = (lateness > cfg_late_tol_i);

   assign pop       = (state_q == S_WAIT) && !q_empty && head_due && !bus.flush_i;
   assign fire      = pop && !head_late;
   assign late_drop = pop && head_late;

   assign push_req  = bus.sort_req_i && bus.enable_i && !bus.flush_i;
   assign push_ok   = push_req && (!q_full || pop);
   assign ovf_drop  = push_req && q_full && !pop;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (bus.flush_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (!q_empty) state_d = S_WAIT;
            S_WAIT: begin
               if (fire)         state_d = S_PULSE;
               else if (q_empty) state_d = S_IDLE;
            end
            S_PULSE: begin
               if (timer_q == '0) begin
                  if (guard_q != '0) state_d = S_GUARD;
                  else if (q_empty)  state_d = S_IDLE;
                  else               state_d = S_WAIT;
               end
            end
            S_GUARD: begin
               if (timer_q == '0) state_d = q_empty ? S_IDLE : S_WAIT;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- FSM: outputs / pulse timing ----------------
   always_comb begin
      timer_d = timer_q;
      guard_d = guard_q;
      // Trigger is the PULSE state delayed one cycle; flush kills it at once.
      trig_d  = (state_q == S_PULSE) && !bus.flush_i;
      if (fire) begin
         timer_d = (cfg_duration_i == '0) ? '0 : cfg_duration_i - 1'b1;
         guard_d = cfg_guard_i;
      end else if (state_q == S_PULSE) begin
         if (timer_q != '0)       timer_d = timer_q - 1'b1;
         else if (guard_q != '0)  timer_d = guard_q - 1'b1;
      end else if (state_q == S_GUARD && timer_q != '0) begin
         timer_d = timer_q - 1'b1;
      end
   end

   // ---------------- queue and timestamp ----------------
   always_comb begin
      ts_d      = ts_q + 1'b1;
      due_mem_d = due_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      if (bus.flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         // When full, the popped head slot is the one the push overwrites.
         if (push_ok) begin
            due_mem_d[wr_ptr_q] = ts_q + cfg_delay_i;
            wr_ptr_d            = wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
         level_d = level_q + (QLOG2+1)'(push_ok) - (QLOG2+1)'(pop);
      end
   end

   // ---------------- saturating counters ----------------
   always_comb begin
      drop_n   = {1'b0, late_drop} + {1'b0, ovf_drop};
      drop_sum = {1'b0, dropped_cnt_q} + (TW+1)'(drop_n);
      issued_cnt_d  = issued_cnt_q;
      dropped_cnt_d = dropped_cnt_q;
      if (cnt_clr_i) begin
         issued_cnt_d  = '0;
         dropped_cnt_d = '0;
      end else begin
         if (fire && issued_cnt_q != '1) issued_cnt_d = issued_cnt_q + 1'b1;
         dropped_cnt_d = drop_sum[TW] ? '1 : drop_sum[TW-1:0];
      end
   end

   always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
      if (adc_rst_i) begin
         ts_q          <= TS_INIT;
         for (int i = 0; i < DEPTH; i++) due_mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         timer_q       <= '0;
         guard_q       <= '0;
         issued_cnt_q  <= '0;
         dropped_cnt_q <= '0;
         trig_q        <= 1'b0;
      end else begin
         ts_q          <= ts_d;
         due_mem_q     <= due_mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         timer_q       <= timer_d;
         guard_q       <= guard_d;
         issued_cnt_q  <= issued_cnt_d;
         dropped_cnt_q <= dropped_cnt_d;
         trig_q        <= trig_d;
      end
   end

   assign bus.sort_trig_o = trig_q;
   assign bus.busy_o      = (state_q != S_IDLE) || !q_empty;
   assign bus.level_o     = level_q;
   assign issued_cnt_o    = issued_cnt_q;
   assign dropped_cnt_o   = dropped_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fads_sort_scheduler.sv
// ============================================================================
// tb_fads_sort_scheduler : directed checks of the sort scheduler, with a
//                          second instance started near timestamp wrap.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_fads_sort_scheduler;
   localparam int TW    = 32;
   localparam int QLOG2 = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cnt_clr;
   logic [TW-1:0] cfg_delay, cfg_duration, cfg_guard, cfg_tol;
   logic [TW-1:0] issued, dropped, w_issued, w_dropped;

   always #5 clk = ~clk;

   fads_sort_scheduler_if #(.QLOG2(QLOG2)) bus  ();
   fads_sort_scheduler_if #(.QLOG2(QLOG2)) wbus ();

   fads_sort_scheduler #(.QLOG2(QLOG2), .TW(TW)) dut (
      .adc_clk_i      (clk),
      .adc_rst_i      (rst),
      .bus            (bus),
      .cnt_clr_i      (cnt_clr),
      .cfg_delay_i    (cfg_delay),
      .cfg_duration_i (cfg_duration),
      .cfg_guard_i    (cfg_guard),
      .cfg_late_tol_i (cfg_tol),
      .issued_cnt_o   (issued),
      .dropped_cnt_o  (dropped)
   );

   fads_sort_scheduler #(.QLOG2(QLOG2), .TW(TW), .TS_INIT(32'hFFFF_FFFB)) u_wrap (
      .adc_clk_i      (clk),
      .adc_rst_i      (rst),
      .bus            (wbus),
      .cnt_clr_i      (cnt_clr),
      .cfg_delay_i    (cfg_delay),
      .cfg_duration_i (cfg_duration),
      .cfg_guard_i    (cfg_guard),
      .cfg_late_tol_i (cfg_tol),
      .issued_cnt_o   (w_issued),
      .dropped_cnt_o  (w_dropped)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_cfg(input int d, input int dur, input int g, input int tol);
      cfg_delay    = TW'(d);
      cfg_duration = TW'(dur);
      cfg_guard    = TW'(g);
      cfg_tol      = TW'(tol);
   endtask

   task automatic clear_counts();
      cnt_clr = 1'b1;
      tick(1);
      cnt_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      cnt_clr = 1'b0;
      set_cfg(0, 0, 0, 0);
      bus.sort_req_i  = 1'b0; bus.enable_i  = 1'b1; bus.flush_i  = 1'b0;
      wbus.sort_req_i = 1'b0; wbus.enable_i = 1'b1; wbus.flush_i = 1'b0;
      tick(2);

      // Reset state
      check("rst_trig",    bus.sort_trig_o, 0);
      check("rst_level",   bus.level_o, 0);
      check("rst_busy",    bus.busy_o, 0);
      check("rst_issued",  issued, 0);
      check("rst_dropped", dropped, 0);
      rst = 1'b0;
      tick(1);

      // Single request on both instances; the second wraps ts during the wait
      set_cfg(10, 5, 0, 4);
      bus.sort_req_i = 1'b1; wbus.sort_req_i = 1'b1;
      tick(1);
      bus.sort_req_i = 1'b0; wbus.sort_req_i = 1'b0;
      check("single_level_c1", bus.level_o, 1);
      tick(10);
      check("single_trig_c11", bus.sort_trig_o, 0);
      check("wrap_trig_c11",   wbus.sort_trig_o, 0);
      tick(1);
      check("single_trig_c12", bus.sort_trig_o, 1);
      check("wrap_trig_c12",   wbus.sort_trig_o, 1);
      tick(4);
      check("single_trig_c16", bus.sort_trig_o, 1);
      tick(1);
      check("single_trig_c17", bus.sort_trig_o, 0);
      check("single_issued",   issued, 1);
      check("single_level",    bus.level_o, 0);
      check("single_busy",     bus.busy_o, 0);
      check("wrap_issued",     w_issued, 1);

      // Enable low: request ignored and not counted
      clear_counts();
      bus.enable_i = 1'b0; bus.sort_req_i = 1'b1;
      tick(1);
      bus.enable_i = 1'b1; bus.sort_req_i = 1'b0;
      check("en_level", bus.level_o, 0);
      for (int i = 0; i < 15; i++) begin
         tick(1);
         check("en_trig", bus.sort_trig_o, 0);
      end
      check("en_issued",  issued, 0);
      check("en_dropped", dropped, 0);

      // Overlap: second request arrives too late after pulse + guard
      set_cfg(100, 50, 20, 10);
      bus.sort_req_i = 1'b1; tick(1); bus.sort_req_i = 1'b0;
      tick(29);
      bus.sort_req_i = 1'b1; tick(1); bus.sort_req_i = 1'b0;
      tick(49);
      bus.sort_req_i = 1'b1; tick(1); bus.sort_req_i = 1'b0;
      check("ovl_level_c81", bus.level_o, 3);
      tick(20);
      check("ovl_trig_c101", bus.sort_trig_o, 0);
      tick(1);
      check("ovl_trig_c102", bus.sort_trig_o, 1);
      tick(49);
      check("ovl_trig_c151", bus.sort_trig_o, 1);
      tick(1);
      check("ovl_trig_c152", bus.sort_trig_o, 0);
      tick(20);
      check("ovl_dropped_c172", dropped, 1);
      check("ovl_issued_c172",  issued, 1);
      tick(9);
      check("ovl_trig_c181", bus.sort_trig_o, 0);
      tick(1);
      check("ovl_trig_c182", bus.sort_trig_o, 1);
      tick(50);
      check("ovl_trig_c232", bus.sort_trig_o, 0);
      check("ovl_issued",    issued, 2);
      check("ovl_dropped",   dropped, 1);
      tick(30);
      check("ovl_busy_end",  bus.busy_o, 0);

      // Flush mid-pulse with a request in the same cycle
      clear_counts();
      set_cfg(5, 10, 0, 100);
      bus.sort_req_i = 1'b1; tick(3); bus.sort_req_i = 1'b0;
      check("fl_level_c3", bus.level_o, 3);
      tick(5);
      check("fl_trig_c8",  bus.sort_trig_o, 1);
      check("fl_level_c8", bus.level_o, 2);
      bus.flush_i = 1'b1; bus.sort_req_i = 1'b1;
      tick(1);
      bus.flush_i = 1'b0; bus.sort_req_i = 1'b0;
      check("fl_trig",    bus.sort_trig_o, 0);
      check("fl_level",   bus.level_o, 0);
      check("fl_busy",    bus.busy_o, 0);
      check("fl_issued",  issued, 1);
      check("fl_dropped", dropped, 0);
      tick(5);
      check("fl_trig_after", bus.sort_trig_o, 0);

      // Overflow: nine back-to-back requests into an 8-deep queue
      clear_counts();
      set_cfg(1000, 2, 0, 100);
      bus.sort_req_i = 1'b1; tick(9); bus.sort_req_i = 1'b0;
      check("ovf_level",   bus.level_o, 8);
      check("ovf_dropped", dropped, 1);
      check("ovf_issued0", issued, 0);
      tick(993);
      check("ovf_trig_c1002", bus.sort_trig_o, 1);
      tick(1);
      check("ovf_trig_c1003", bus.sort_trig_o, 1);
      tick(1);
      check("ovf_trig_c1004", bus.sort_trig_o, 0);
      for (int i = 0; i < 200 && issued != 8; i++) tick(1);
      tick(5);
      check("ovf_issued",      issued, 8);
      check("ovf_dropped_end", dropped, 1);
      check("ovf_level_end",   bus.level_o, 0);
      check("ovf_busy_end",    bus.busy_o, 0);

      // Counter clear
      clear_counts();
      check("clr_issued",  issued, 0);
      check("clr_dropped", dropped, 0);

      // Full queue with a pop and a push in the same cycle
      set_cfg(20, 2, 0, 100);
      bus.sort_req_i = 1'b1; tick(8); bus.sort_req_i = 1'b0;
      check("fpp_level_c8", bus.level_o, 8);
      tick(12);
      check("fpp_level_c20", bus.level_o, 8);
      bus.sort_req_i = 1'b1; tick(1); bus.sort_req_i = 1'b0;
      check("fpp_level_c21", bus.level_o, 8);
      check("fpp_dropped",   dropped, 0);
      check("fpp_issued",    issued, 1);
      bus.flush_i = 1'b1; tick(1); bus.flush_i = 1'b0;
      check("fpp_level_flush", bus.level_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire
